// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback slice: data width, ALU op encoding and the
// result-queue entry layout.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  // Queue entries carry a fixed-width destination; NREG must not exceed 2**DEST_W.
  localparam int unsigned DEST_W = 4;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpXor = 3'b011
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic [DEST_W-1:0] dest;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_queue.sv
// In-order result queue feeding the register file. With ALU_WB_BYPASS_EN defined it
// also offers a youngest-match lookup of queued results for two read ports.
module alu_wb_queue
  import alu_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned CW = $clog2(QDEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  wb_entry_t           push_entry,
  input  logic                pop,
  output wb_entry_t           head,
  output logic [CW-1:0]       count
`ifdef ALU_WB_BYPASS_EN
  ,
  input  logic [DEST_W-1:0]   look_addr_a,
  input  logic [DEST_W-1:0]   look_addr_b,
  output logic                hit_a,
  output logic                hit_b,
  output logic [DATA_W-1:0]   hit_data_a,
  output logic [DATA_W-1:0]   hit_data_b
`endif
);

  localparam int unsigned PW = $clog2(QDEPTH);

  wb_entry_t         mem_q [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;

  // Payload storage needs no reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // QDEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

`ifdef ALU_WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    idx        = '0;
    hit_a      = 1'b0;
    hit_b      = 1'b0;
    hit_data_a = '0;
    hit_data_b = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (mem_q[idx].dest == look_addr_a) begin
          hit_a      = 1'b1;
          hit_data_a = mem_q[idx].data;
        end
        if (mem_q[idx].dest == look_addr_b) begin
          hit_b      = 1'b1;
          hit_data_b = mem_q[idx].data;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: queues ALU results and drains them into a small register file, with
// external writes taking priority. Optional read bypass via macro ALU_WB_BYPASS_EN.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned NREG   = 4,
  localparam int unsigned AW = $clog2(NREG),
  localparam int unsigned CW = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_zero,
  input  logic [AW-1:0]     in_dest,
  input  logic              ext_we,
  input  logic [AW-1:0]     ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              zero_flag,
  output logic [CW-1:0]     pending
);

  localparam logic [CW-1:0] QDepthC = CW'(QDEPTH);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              zero_flag_q;
  logic              push, drain;
  wb_entry_t         push_entry, head;
  logic [CW-1:0]     count;

  // Ready depends only on the registered count, never on in_valid.
  assign in_ready   = (count < QDepthC);
  assign push       = in_valid && in_ready;
  assign drain      = (count != '0) && !ext_we;
  assign push_entry = '{data: in_data, zero: in_zero, dest: DEST_W'(in_dest)};

`ifdef ALU_WB_BYPASS_EN
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] hit_data_a, hit_data_b;
`endif

  alu_wb_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (drain),
    .head       (head),
    .count      (count)
`ifdef ALU_WB_BYPASS_EN
    ,
    .look_addr_a (DEST_W'(rd_addr_a)),
    .look_addr_b (DEST_W'(rd_addr_b)),
    .hit_a       (hit_a),
    .hit_b       (hit_b),
    .hit_data_a  (hit_data_a),
    .hit_data_b  (hit_data_b)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) regs_q[r] <= '0;
      zero_flag_q <= 1'b0;
    end else if (ext_we) begin
      regs_q[ext_addr] <= ext_data;
    end else if (drain) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (head.dest == DEST_W'(r)) regs_q[r] <= head.data;
      end
      zero_flag_q <= head.zero;
    end
  end

`ifdef ALU_WB_BYPASS_EN
  assign rd_data_a = hit_a ? hit_data_a : regs_q[rd_addr_a];
  assign rd_data_b = hit_b ? hit_data_b : regs_q[rd_addr_b];
`else
  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
`endif

  assign zero_flag = zero_flag_q;
  assign pending   = count;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback (QDEPTH=2, NREG=4); expectations follow
// ALU_WB_BYPASS_EN when it is defined.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_zero, ext_we, zero_flag;
  logic [7:0] in_data, ext_data, rd_data_a, rd_data_b;
  logic [1:0] in_dest, ext_addr, rd_addr_a, rd_addr_b, pending;

  int checks   = 0;
  int failures = 0;

`ifdef ALU_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  alu_writeback #(.QDEPTH(2), .NREG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_zero   (in_zero),
    .in_dest   (in_dest),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .zero_flag (zero_flag),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic z, input logic [1:0] dst);
    in_valid = 1'b1;
    in_data  = d;
    in_zero  = z;
    in_dest  = dst;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_zero = 1'b0; in_dest = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; rd_addr_a = 2'd1; rd_addr_b = 2'd2;
    #2;
    check("rst_pending", 8'(pending), 8'd0);
    check("rst_zero", 8'(zero_flag), 8'd0);
    check("rst_rd_a", rd_data_a, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_ready", 8'(in_ready), 8'd1);

    // First result: 3C -> reg1, one edge of latency to the register file.
    push(8'h3C, 1'b0, 2'd1);
    tick();
    in_valid = 1'b0;
    check("t1_pending1", 8'(pending), 8'd1);
    check("t1_rd_early", rd_data_a, Byp ? 8'h3C : 8'h00);
    tick();
    check("t1_rd_reg1", rd_data_a, 8'h3C);
    check("t1_pending0", 8'(pending), 8'd0);
    check("t1_zero", 8'(zero_flag), 8'd0);

    // Single zero result to reg2.
    push(8'h00, 1'b1, 2'd2);
    tick();
    in_valid = 1'b0;
    check("t2_pending1", 8'(pending), 8'd1);
    check("t2_zero_early", 8'(zero_flag), 8'd0);
    tick();
    check("t2_pending0", 8'(pending), 8'd0);
    check("t2_zero", 8'(zero_flag), 8'd1);
    check("t2_reg2", rd_data_b, 8'h00);

    // External write beats the queued AA -> reg1 and leaves zero_flag alone.
    push(8'hAA, 1'b0, 2'd1);
    tick();
    in_valid = 1'b0;
    ext_we = 1'b1; ext_addr = 2'd1; ext_data = 8'h55;
    tick();
    check("t3_reg1_ext", rd_data_a, Byp ? 8'hAA : 8'h55);
    check("t3_zero_hold", 8'(zero_flag), 8'd1);
    check("t3_pending", 8'(pending), 8'd1);
    ext_we = 1'b0;
    tick();
    check("t3_reg1_drain", rd_data_a, 8'hAA);
    check("t3_zero", 8'(zero_flag), 8'd0);
    check("t3_pending0", 8'(pending), 8'd0);

    // Back-pressure with ext_we held; bypass visibility on reg0.
    ext_we = 1'b1; ext_addr = 2'd3; ext_data = 8'h77;
    rd_addr_a = 2'd0; rd_addr_b = 2'd3;
    push(8'h11, 1'b0, 2'd0);
    tick();
    check("t4_pending1", 8'(pending), 8'd1);
    check("t4_ready1", 8'(in_ready), 8'd1);
    push(8'h22, 1'b0, 2'd0);
    tick();
    check("t4_pending2", 8'(pending), 8'd2);
    check("t4_full", 8'(in_ready), 8'd0);
    check("t4_bypass", rd_data_a, Byp ? 8'h22 : 8'h00);
    push(8'h33, 1'b0, 2'd2);
    tick();
    check("t4_held", 8'(pending), 8'd2);
    check("t4_ext_reg3", rd_data_b, 8'h77);
    ext_we = 1'b0;
    tick();
    check("t4_drain1", 8'(pending), 8'd1);
    check("t4_ready_again", 8'(in_ready), 8'd1);
    check("t4_reg0_11", rd_data_a, Byp ? 8'h22 : 8'h11);
    tick();
    in_valid = 1'b0;
    rd_addr_b = 2'd2;
    check("t4_acc_drain", 8'(pending), 8'd1);
    check("t4_reg0_22", rd_data_a, 8'h22);
    check("t4_reg2_q", rd_data_b, Byp ? 8'h33 : 8'h00);
    tick();
    check("t4_reg2_33", rd_data_b, 8'h33);
    check("t4_pending0", 8'(pending), 8'd0);

    // Eight back-to-back results to reg3 with continuous drain.
    rd_addr_b = 2'd3;
    for (int k = 1; k <= 8; k++) begin
      push(8'(k), (k == 8), 2'd3);
      tick();
      check("t5_pending", 8'(pending), 8'd1);
      check("t5_reg3", rd_data_b, Byp ? 8'(k) : ((k == 1) ? 8'h77 : 8'(k - 1)));
    end
    in_valid = 1'b0;
    tick();
    check("t5_reg3_last", rd_data_b, 8'h08);
    check("t5_pending0", 8'(pending), 8'd0);
    check("t5_zero", 8'(zero_flag), 8'd1);
    tick();
    check("t5_empty_zero_hold", 8'(zero_flag), 8'd1);
    check("t5_empty_reg3_hold", rd_data_b, 8'h08);

    // Reset with two results queued: none may reach the register file.
    ext_we = 1'b1; ext_addr = 2'd0; ext_data = 8'h5A;
    push(8'h44, 1'b0, 2'd1);
    tick();
    push(8'h66, 1'b0, 2'd2);
    tick();
    check("t6_pending2", 8'(pending), 8'd2);
    in_valid = 1'b0; ext_we = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pending", 8'(pending), 8'd0);
    check("t6_rst_zero", 8'(zero_flag), 8'd0);
    check("t6_rst_ready", 8'(in_ready), 8'd1);
    for (int r = 0; r < 4; r++) begin
      rd_addr_a = 2'(r);
      #1;
      check("t6_rst_reg", rd_data_a, 8'h00);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("t6_post_pending", 8'(pending), 8'd0);
    check("t6_post_zero", 8'(zero_flag), 8'd0);
    for (int r = 0; r < 4; r++) begin
      rd_addr_a = 2'(r);
      #1;
      check("t6_post_reg", rd_data_a, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
